ram_arbiter: RTL and testbench

//  Multicore RAM-port arbiter: shares the single RAM port between CPUS cores, each with an I and a D requester.

---
 rtl/ram_arbiter_pkg.sv | 17 +
 rtl/ram_arbiter_if.sv | 35 +++
 rtl/ram_arbiter_rr_picker.sv | 27 ++
 rtl/ram_arbiter.sv | 121 ++++++++++++
 tb/tb_ram_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared types for the multicore RAM-port arbiter: word/RAM-state types and FSM encodings.
// The RAM model and the caches use the same ramstate_t encoding.
package ram_arbiter_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

endpackage

// File: rtl/ram_arbiter_if.sv
// Bundle of per-core cache requests and the shared RAM port.
// The slave side is the arbiter; the master side is the caches plus the RAM model.
interface ram_arbiter_if
  import ram_arbiter_pkg::*;
#(
  parameter int CPUS = 2
);
  logic [CPUS-1:0]        iREN;
  logic [CPUS-1:0]        dREN;
  logic [CPUS-1:0]        dWEN;
  word_t [CPUS-1:0]       iaddr;
  word_t [CPUS-1:0]       daddr;
  word_t [CPUS-1:0]       dstore;
  logic [CPUS-1:0]        iwait;
  logic [CPUS-1:0]        dwait;
  word_t [CPUS-1:0]       iload;
  word_t [CPUS-1:0]       dload;
  logic                   ramREN;
  logic                   ramWEN;
  word_t                  ramaddr;
  word_t                  ramstore;
  word_t                  ramload;
  ramstate_t              ramstate;
  logic                   arb_timeout;

  modport slave (
    input  iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
    output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, arb_timeout
  );

  modport master (
    output iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
    input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, arb_timeout
  );
endinterface

// File: rtl/ram_arbiter_rr_picker.sv
// Combinational round-robin picker: first active request at or after ptr, wrapping modulo N.
module rr_picker #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          valid,
  output logic [PW-1:0] idx
);
  logic [N-1:0]  rot;
  logic [PW-1:0] off;

  // rot[k] is the request k positions after ptr
  always_comb begin
    rot = '0;
    for (int k = 0; k < N; k++) begin
      rot[k] = req[PW'((int'(ptr) + k) % N)];
    end
    valid = |rot;
    off = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) off = PW'(k);
    end
    idx = PW'((int'(ptr) + int'(off)) % N);
  end
endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one RAM port among 2*CPUS cache requesters (D of core c = 2c, I = 2c+1).
// One word access per grant; a watchdog abandons accesses the RAM never completes.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int CPUS    = 2,
  parameter int TIMEOUT = 255
) (
  input logic          CLK,
  input logic          RST,
  ram_arbiter_if.slave bus
);
  localparam int N  = 2 * CPUS;
  localparam int PW = $clog2(N);
  localparam int CW = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);

  logic [0:0]    state;
  logic [PW-1:0] ptr, grant, pick_idx, ptr_next;
  logic [WW-1:0] wdog, wdog_inc;
  logic [N-1:0]  req;
  logic [CW-1:0] gcore;
  logic          pick_valid, is_i, grant_live, hit, tmo, timeout_q;
  logic          ren, wen;
  word_t         addr, store;

  always_comb begin
    req = '0;
    for (int c = 0; c < CPUS; c++) begin
      req[2*c]   = bus.dREN[c] | bus.dWEN[c];
      req[2*c+1] = bus.iREN[c];
    end
  end

  rr_picker #(.N(N), .PW(PW)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign gcore      = CW'(grant >> 1);
  assign is_i       = grant[0];
  assign grant_live = req[grant];
  assign hit        = (state == S_BUSY) && grant_live && (bus.ramstate == ACCESS);
  assign wdog_inc   = wdog + WW'(1);
  assign tmo        = (wdog_inc == WW'(TIMEOUT));
  assign ptr_next   = (grant == PW'(N - 1)) ? '0 : grant + PW'(1);

  // A dropped request or a completed access both release the grant and demote it
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      ptr       <= '0;
      grant     <= '0;
      wdog      <= '0;
      timeout_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_valid) begin
            grant <= pick_idx;
            wdog  <= '0;
            state <= S_BUSY;
          end
        end
        default: begin
          if (!grant_live || bus.ramstate == ACCESS) begin
            state <= S_IDLE;
            ptr   <= ptr_next;
          end else if (tmo) begin
            timeout_q <= 1'b1;
            wdog      <= wdog_inc;
            state     <= S_IDLE;
            ptr       <= ptr_next;
          end else begin
            wdog <= wdog_inc;
          end
        end
      endcase
    end
  end

  always_comb begin
    ren       = 1'b0;
    wen       = 1'b0;
    addr      = '0;
    store     = '0;
    bus.iwait = '1;
    bus.dwait = '1;
    if (state == S_BUSY) begin
      if (is_i) begin
        ren  = 1'b1;
        addr = bus.iaddr[gcore];
      end else begin
        wen   = bus.dWEN[gcore];
        ren   = bus.dREN[gcore] & ~bus.dWEN[gcore];
        addr  = bus.daddr[gcore];
        store = bus.dstore[gcore];
      end
      if (hit) begin
        if (is_i) bus.iwait[gcore] = 1'b0;
        else      bus.dwait[gcore] = 1'b0;
      end
      if (!(ren || wen)) begin
        addr  = '0;
        store = '0;
      end
    end
    for (int c = 0; c < CPUS; c++) begin
      bus.iload[c] = bus.ramload;
      bus.dload[c] = bus.ramload;
    end
  end

  assign bus.ramREN      = ren;
  assign bus.ramWEN      = wen;
  assign bus.ramaddr     = addr;
  assign bus.ramstore    = store;
  assign bus.arb_timeout = timeout_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: vector table, directed corner sequences, then random traffic vs a grant-level model.
`timescale 1ns/1ps
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;

  localparam int CPUS = 2;
  localparam int N    = 2 * CPUS;
  localparam int TMO  = 8;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  ram_arbiter_if #(.CPUS(CPUS)) bus();
  ram_arbiter #(.CPUS(CPUS), .TIMEOUT(TMO)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          r;
    logic        ren;
    logic        wen;
    word_t       addr;
    word_t       store;
    logic        exp_ren;
    logic        exp_wen;
    word_t       exp_addr;
    word_t       exp_store;
    logic [3:0]  exp_wait;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic samp();
    @(negedge CLK);
  endtask

  function automatic logic [3:0] waitvec();
    logic [3:0] w;
    for (int c = 0; c < CPUS; c++) begin
      w[2*c]   = bus.dwait[c];
      w[2*c+1] = bus.iwait[c];
    end
    return w;
  endfunction

  function automatic logic [3:0] reqvec();
    logic [3:0] q;
    for (int c = 0; c < CPUS; c++) begin
      q[2*c]   = bus.dREN[c] | bus.dWEN[c];
      q[2*c+1] = bus.iREN[c];
    end
    return q;
  endfunction

  task automatic clear_in();
    bus.iREN = '0;
    bus.dREN = '0;
    bus.dWEN = '0;
    for (int c = 0; c < CPUS; c++) begin
      bus.iaddr[c]  = 32'hBAD0_0100 + 32'(c);
      bus.daddr[c]  = 32'hBAD0_0200 + 32'(c);
      bus.dstore[c] = 32'h5555_0000 + 32'(c);
    end
    bus.ramstate = FREE;
    bus.ramload  = '0;
  endtask

  task automatic apply_vec(input vec_t v, input int i);
    int    c;
    word_t ld;
    c = v.r / 2;
    tick();
    clear_in();
    if (v.r % 2 == 1) begin
      bus.iREN[c]  = 1'b1;
      bus.iaddr[c] = v.addr;
    end else begin
      bus.dREN[c]   = v.ren;
      bus.dWEN[c]   = v.wen;
      bus.daddr[c]  = v.addr;
      bus.dstore[c] = v.store;
    end
    tick();
    bus.ramstate = BUSY;
    samp();
    check($sformatf("vec%0d_addr", i), bus.ramaddr, v.exp_addr);
    check($sformatf("vec%0d_ren", i), bus.ramREN, v.exp_ren);
    check($sformatf("vec%0d_wen", i), bus.ramWEN, v.exp_wen);
    if (v.r % 2 == 0) check($sformatf("vec%0d_store", i), bus.ramstore, v.exp_store);
    check($sformatf("vec%0d_wait_busy", i), waitvec(), 4'hF);
    tick();
    ld = $urandom;
    bus.ramstate = ACCESS;
    bus.ramload  = ld;
    samp();
    check($sformatf("vec%0d_wait_acc", i), waitvec(), v.exp_wait);
    check($sformatf("vec%0d_load", i), bus.iload[c] ^ bus.dload[1-c], ld ^ ld);
    check($sformatf("vec%0d_dload", i), bus.dload[c], ld);
    tick();
    clear_in();
    samp();
    check($sformatf("vec%0d_idle_en", i), {bus.ramREN, bus.ramWEN}, 0);
    check($sformatf("vec%0d_idle_addr", i), bus.ramaddr, 0);
    check($sformatf("vec%0d_idle_wait", i), waitvec(), 4'hF);
  endtask

  word_t      rr_addr[4];
  logic [3:0] pend, served, reqv, ew;
  int         ram_cnt, m_ptr, m_grant, c, kind;
  bit         m_busy;
  logic       e_ren, e_wen;
  word_t      e_addr;

  initial begin
    vecs[0] = '{1, 1'b0, 1'b0, 32'h0000_0040, 32'h0,         1'b1, 1'b0, 32'h0000_0040, 32'h0,         4'b1101};
    vecs[1] = '{2, 1'b0, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'b1011};
    vecs[2] = '{0, 1'b1, 1'b0, 32'h0000_0200, 32'h0000_1234, 1'b1, 1'b0, 32'h0000_0200, 32'h0000_1234, 4'b1110};
    vecs[3] = '{2, 1'b1, 1'b1, 32'h0000_0300, 32'hCAFE_F00D, 1'b0, 1'b1, 32'h0000_0300, 32'hCAFE_F00D, 4'b1011};
    vecs[4] = '{3, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,         1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,         4'b0111};
    vecs[5] = '{0, 1'b0, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 4'b1110};

    // reset with a live request: arbiter must stay quiet
    RST = 1'b1;
    clear_in();
    bus.iREN[0] = 1'b1;
    tick();
    tick();
    samp();
    check("rst_wait", waitvec(), 4'hF);
    check("rst_en", {bus.ramREN, bus.ramWEN}, 0);
    check("rst_addr", bus.ramaddr, 0);
    check("rst_store", bus.ramstore, 0);
    check("rst_tmo", bus.arb_timeout, 0);
    tick();
    RST = 1'b0;
    clear_in();

    // all four requesters held active; ACCESS on the second BUSY cycle
    tick();
    bus.dREN = 2'b11;
    bus.iREN = 2'b11;
    bus.daddr[0] = 32'h1000; bus.iaddr[0] = 32'h2000;
    bus.daddr[1] = 32'h1100; bus.iaddr[1] = 32'h2100;
    rr_addr = '{32'h1000, 32'h2000, 32'h1100, 32'h2100};
    for (int g = 0; g < 8; g++) begin
      tick();
      bus.ramstate = BUSY;
      samp();
      check($sformatf("rr%0d_addr", g), bus.ramaddr, rr_addr[g % 4]);
      check($sformatf("rr%0d_wait_busy", g), waitvec(), 4'hF);
      tick();
      bus.ramstate = ACCESS;
      samp();
      check($sformatf("rr%0d_wait_acc", g), waitvec(), 4'hF & ~(4'b1 << (g % 4)));
      tick();
      bus.ramstate = FREE;
      samp();
      check($sformatf("rr%0d_idle", g), {bus.ramREN, bus.ramWEN}, 0);
    end
    tick();
    clear_in();

    // watchdog: RAM stuck BUSY on a D0 write
    tick();
    bus.dWEN[0]   = 1'b1;
    bus.daddr[0]  = 32'h500;
    bus.dstore[0] = 32'h11;
    bus.ramstate  = BUSY;
    for (int k = 1; k <= TMO; k++) begin
      tick();
      samp();
      check($sformatf("to_wen%0d", k), bus.ramWEN, 1);
      check($sformatf("to_quiet%0d", k), bus.arb_timeout, 0);
      check($sformatf("to_wait%0d", k), waitvec(), 4'hF);
    end
    tick();
    bus.iREN[0]  = 1'b1;
    bus.iaddr[0] = 32'h600;
    samp();
    check("to_flag", bus.arb_timeout, 1);
    check("to_idle_en", {bus.ramREN, bus.ramWEN}, 0);
    tick();
    samp();
    check("to_next_addr", bus.ramaddr, 32'h600);
    check("to_next_ren", bus.ramREN, 1);
    tick();
    bus.ramstate = ACCESS;
    samp();
    check("to_next_wait", waitvec(), 4'b1101);
    check("to_sticky", bus.arb_timeout, 1);

    // reset in the middle of a D0 write
    tick();
    bus.iREN     = '0;
    bus.ramstate = BUSY;
    tick();
    samp();
    check("rst_mid_pre_wen", bus.ramWEN, 1);
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    bus.dWEN = '0;
    bus.dREN = 2'b11;
    bus.iREN = 2'b11;
    bus.daddr[0] = 32'h700;
    bus.daddr[1] = 32'h710;
    bus.ramstate = FREE;
    samp();
    check("rst_mid_wen", bus.ramWEN, 0);
    check("rst_mid_ren", bus.ramREN, 0);
    check("rst_mid_wait", waitvec(), 4'hF);
    check("rst_mid_tmo", bus.arb_timeout, 0);
    check("rst_mid_addr", bus.ramaddr, 0);
    tick();
    samp();
    check("rst_mid_ptr0", bus.ramaddr, 32'h700);
    tick();
    clear_in();
    tick();

    // I0 granted then dropped before ACCESS
    tick();
    bus.iREN[0]  = 1'b1;
    bus.iaddr[0] = 32'h800;
    bus.ramstate = BUSY;
    tick();
    samp();
    check("ab_addr", bus.ramaddr, 32'h800);
    check("ab_wait_live", waitvec(), 4'hF);
    tick();
    bus.iREN[0] = 1'b0;
    samp();
    check("ab_wait_drop", waitvec(), 4'hF);
    tick();
    bus.dREN     = 2'b11;
    bus.daddr[0] = 32'h900;
    bus.daddr[1] = 32'h910;
    samp();
    check("ab_idle_wait", waitvec(), 4'hF);
    tick();
    samp();
    check("ab_ptr2_addr", bus.ramaddr, 32'h910);
    tick();
    bus.ramstate = ACCESS;
    samp();
    check("ab_d1_wait", waitvec(), 4'b1011);
    tick();
    clear_in();

    foreach (vecs[i]) apply_vec(vecs[i], i);

    // random traffic: requests held until served, RAM completes within 5 busy cycles
    tick();
    RST = 1'b1;
    clear_in();
    tick();
    RST = 1'b0;
    pend = '0; served = '0;
    ram_cnt = 0; m_ptr = 0; m_grant = 0; m_busy = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      tick();
      for (int r = 0; r < N; r++) begin
        c = r / 2;
        if (served[r]) begin
          pend[r] = 1'b0;
          served[r] = 1'b0;
          if (r % 2 == 1) bus.iREN[c] = 1'b0;
          else begin bus.dREN[c] = 1'b0; bus.dWEN[c] = 1'b0; end
        end else if (!pend[r] && $urandom_range(2) == 0) begin
          pend[r] = 1'b1;
          if (r % 2 == 1) begin
            bus.iREN[c]  = 1'b1;
            bus.iaddr[c] = $urandom;
          end else begin
            kind = int'($urandom_range(2));
            bus.dREN[c]   = (kind != 1);
            bus.dWEN[c]   = (kind != 0);
            bus.daddr[c]  = $urandom;
            bus.dstore[c] = $urandom;
          end
        end
      end
      bus.ramload = $urandom;
      #1;
      if (bus.ramREN || bus.ramWEN) begin
        ram_cnt++;
        if (ram_cnt >= 5 || $urandom_range(2) == 0) begin
          bus.ramstate = ACCESS;
          ram_cnt = 0;
        end else bus.ramstate = ($urandom_range(1) == 0) ? BUSY : ERROR;
      end else bus.ramstate = ($urandom_range(1) == 0) ? FREE : BUSY;
      samp();
      reqv = reqvec();
      if (!m_busy) begin
        check("rnd_idle_wait", waitvec(), 4'hF);
        check("rnd_idle_en", {bus.ramREN, bus.ramWEN}, 0);
        if (reqv != 0) begin
          for (int k = N - 1; k >= 0; k--) begin
            if (reqv[(m_ptr + k) % N]) m_grant = (m_ptr + k) % N;
          end
          m_busy = 1'b1;
        end
      end else begin
        c = m_grant / 2;
        if (m_grant % 2 == 1) begin
          e_addr = bus.iaddr[c]; e_ren = 1'b1; e_wen = 1'b0;
        end else begin
          e_addr = bus.daddr[c];
          e_wen  = bus.dWEN[c];
          e_ren  = bus.dREN[c] & ~bus.dWEN[c];
          check("rnd_store", bus.ramstore, bus.dstore[c]);
        end
        check("rnd_addr", bus.ramaddr, e_addr);
        check("rnd_ren", bus.ramREN, e_ren);
        check("rnd_wen", bus.ramWEN, e_wen);
        ew = 4'hF;
        if (bus.ramstate == ACCESS) begin
          ew[m_grant] = 1'b0;
          m_busy = 1'b0;
          m_ptr = (m_grant + 1) % N;
          served[m_grant] = 1'b1;
        end
        check("rnd_wait", waitvec(), ew);
      end
    end
    check("rnd_no_timeout", bus.arb_timeout, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
